reflector_prog: RTL and testbench

REFLECTOR_PROG -- requirements
Module: reflector_prog

---
 rtl/reflector_prog.sv | 175 +++++++++++++++++
 tb/tb_reflector_prog.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reflector_prog.sv
// Enigma-style reflector: fixed UKW-B/UKW-C wirings plus a programmable pair table.
// Optional macro REFLECTOR_CHECK_EN adds a post-load involution scan (CHECK state).
module reflector_prog #(
    parameter int N_SYM = 26,
    parameter int W     = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   mode,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [W-1:0] cfg_a,
    input  logic [W-1:0] cfg_b,
    input  logic         cfg_last,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] char_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] char_out,
    output logic         out_err,
    output logic         table_ok,
    output logic         cfg_err,
    output logic [1:0]   state_o
);
    // Every channel (cfg, in, out) transfers on a rising clk edge only when its valid and ready
    // are both high; a producer holds valid and payload steady until that edge.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_CHECK = 2'd2,
        S_READY = 2'd3
    } state_t;

    localparam logic [4:0] UKW_B [26] = '{
        5'd24, 5'd17, 5'd20, 5'd7,  5'd16, 5'd18, 5'd11, 5'd3,  5'd15, 5'd23, 5'd13, 5'd6,  5'd14,
        5'd10, 5'd12, 5'd8,  5'd4,  5'd1,  5'd5,  5'd25, 5'd2,  5'd22, 5'd21, 5'd9,  5'd0,  5'd19};
    localparam logic [4:0] UKW_C [26] = '{
        5'd5,  5'd21, 5'd15, 5'd9,  5'd8,  5'd0,  5'd14, 5'd24, 5'd4,  5'd3,  5'd17, 5'd25, 5'd23,
        5'd22, 5'd6,  5'd2,  5'd19, 5'd10, 5'd20, 5'd16, 5'd18, 5'd1,  5'd13, 5'd12, 5'd7,  5'd11};

    state_t       state_q, state_d;
    logic [W-1:0] table_q [N_SYM];
    logic [W-1:0] table_d [N_SYM];
    logic         table_ok_q, table_ok_d;
    logic         cfg_err_q, cfg_err_d;
    logic         out_valid_q, out_err_q;
    logic [W-1:0] char_out_q;
    logic         cfg_fire, in_fire, beat_ok, eff_prog, map_err;
    logic [W-1:0] map_char;
    logic [4:0]   c5;

`ifdef REFLECTOR_CHECK_EN
    logic [W-1:0] chk_idx_q, chk_idx_d;
    logic         chk_bad_q, chk_bad_d, idx_bad;

    assign idx_bad = (table_q[table_q[chk_idx_q]] != chk_idx_q) || (table_q[chk_idx_q] == chk_idx_q);
`endif

    assign cfg_ready = (state_q != S_CHECK);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign beat_ok   = (cfg_a != cfg_b) && (32'(cfg_a) < N_SYM) && (32'(cfg_b) < N_SYM);
    // The fixed wirings only exist for a 26-letter alphabet; otherwise every mode uses the table.
    assign eff_prog  = (mode == 2'd2) || (N_SYM != 26);
    assign in_ready  = (!out_valid_q || out_ready) && !(eff_prog && !table_ok_q);
    assign in_fire   = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        table_d    = table_q;
        table_ok_d = table_ok_q;
        cfg_err_d  = cfg_err_q;
`ifdef REFLECTOR_CHECK_EN
        chk_idx_d  = chk_idx_q;
        chk_bad_d  = chk_bad_q;
`endif
        if (cfg_fire) begin
            if (state_q == S_IDLE || state_q == S_READY) begin
                for (int i = 0; i < N_SYM; i++) table_d[i] = W'(i);
                table_ok_d = 1'b0;
                cfg_err_d  = 1'b0;
                state_d    = S_LOAD;
            end
            if (beat_ok) begin
                table_d[cfg_a] = cfg_b;
                table_d[cfg_b] = cfg_a;
            end else begin
                cfg_err_d = 1'b1;
            end
            if (cfg_last) begin
`ifdef REFLECTOR_CHECK_EN
                state_d   = S_CHECK;
                chk_idx_d = '0;
                chk_bad_d = 1'b0;
`else
                state_d    = S_READY;
                table_ok_d = 1'b1;
`endif
            end
        end
`ifdef REFLECTOR_CHECK_EN
        if (state_q == S_CHECK) begin
            chk_bad_d = chk_bad_q || idx_bad;
            chk_idx_d = chk_idx_q + 1'b1;
            if (chk_idx_q == W'(N_SYM - 1)) begin
                state_d = S_READY;
                if (chk_bad_q || idx_bad || cfg_err_q) begin
                    cfg_err_d  = 1'b1;
                    table_ok_d = 1'b0;
                end else begin
                    table_ok_d = 1'b1;
                end
            end
        end
`endif
    end

    always_comb begin
        c5       = 5'(char_in);
        map_char = char_in;
        map_err  = 1'b0;
        if (32'(char_in) >= N_SYM) map_err = 1'b1;
        else if (eff_prog)         map_char = table_q[char_in];
        else if (mode == 2'd1)     map_char = W'(UKW_C[c5]);
        else                       map_char = W'(UKW_B[c5]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            table_ok_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            for (int i = 0; i < N_SYM; i++) table_q[i] <= W'(i);
        end else begin
            state_q    <= state_d;
            table_ok_q <= table_ok_d;
            cfg_err_q  <= cfg_err_d;
            table_q    <= table_d;
        end
    end

`ifdef REFLECTOR_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_idx_q <= '0;
            chk_bad_q <= 1'b0;
        end else begin
            chk_idx_q <= chk_idx_d;
            chk_bad_q <= chk_bad_d;
        end
    end
`endif

    // Lookups read table_q before this edge's write, so a load starting now never affects them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            char_out_q  <= '0;
            out_err_q   <= 1'b0;
        end else if (in_fire) begin
            out_valid_q <= 1'b1;
            char_out_q  <= map_char;
            out_err_q   <= map_err;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign char_out  = char_out_q;
    assign out_err   = out_err_q;
    assign table_ok  = table_ok_q;
    assign cfg_err   = cfg_err_q;
    assign state_o   = state_q;
endmodule

// File: tb/tb_reflector_prog.sv
// Self-checking bench for reflector_prog: randomized lookups and loads against a letter-level model.
// Build with or without REFLECTOR_CHECK_EN; expectations follow the macro.
module tb_reflector_prog;
    localparam int N_SYM = 26;
    localparam int W     = 5;
`ifdef REFLECTOR_CHECK_EN
    localparam int CHK_LAT = 26;
`else
    localparam int CHK_LAT = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   mode;
    logic         cfg_valid, cfg_ready, cfg_last;
    logic [W-1:0] cfg_a, cfg_b;
    logic         in_valid, in_ready;
    logic [W-1:0] char_in, char_out;
    logic         out_valid, out_ready, out_err;
    logic         table_ok, cfg_err;
    logic [1:0]   state_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [W:0] exp_q[$];
    logic [W:0] obs_q[$];
    int         cyc_q[$];

    logic [W-1:0] ref_tab [N_SYM];
    bit ref_ok, ref_err, ref_busy;

    reflector_prog #(.N_SYM(N_SYM), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_last(cfg_last),
        .in_valid(in_valid), .in_ready(in_ready), .char_in(char_in),
        .out_valid(out_valid), .out_ready(out_ready), .char_out(char_out), .out_err(out_err),
        .table_ok(table_ok), .cfg_err(cfg_err), .state_o(state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Responses are recorded half a cycle before the edge that transfers them.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            obs_q.push_back({out_err, char_out});
            cyc_q.push_back(cyc);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int i = 0; i < N_SYM; i++) ref_tab[i] = W'(i);
        ref_ok = 0; ref_err = 0; ref_busy = 0;
    endfunction

    function automatic bit ref_involution();
        for (int i = 0; i < N_SYM; i++)
            if (int'(ref_tab[int'(ref_tab[i])]) != i || int'(ref_tab[i]) == i) return 0;
        return 1;
    endfunction

    function automatic void model_beat(input logic [W-1:0] a, input logic [W-1:0] b, input bit last);
        if (!ref_busy) begin
            for (int i = 0; i < N_SYM; i++) ref_tab[i] = W'(i);
            ref_ok = 0; ref_err = 0; ref_busy = 1;
        end
        if (a != b && int'(a) < N_SYM && int'(b) < N_SYM) begin
            ref_tab[int'(a)] = b;
            ref_tab[int'(b)] = a;
        end else begin
            ref_err = 1;
        end
        if (last) begin
            ref_busy = 0;
`ifdef REFLECTOR_CHECK_EN
            if (!ref_err && ref_involution()) ref_ok = 1;
            else begin ref_ok = 0; ref_err = 1; end
`else
            ref_ok = 1;
`endif
        end
    endfunction

    function automatic logic [W:0] ref_map(input logic [1:0] m, input logic [W-1:0] c);
        string b_str = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
        string c_str = "FVPJIAOYEDRZXWGCTKUQSBNMHL";
        int ci = int'(c);
        if (ci >= N_SYM) return {1'b1, c};
        if (m == 2'd2) return {1'b0, ref_tab[ci]};
        if (m == 2'd1) return {1'b0, W'(int'(c_str[ci]) - 65)};
        return {1'b0, W'(int'(b_str[ci]) - 65)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic lookup(input logic [1:0] m, input logic [W-1:0] c, input bit rnd_rdy);
        bit acc = 0;
        mode = m; char_in = c; in_valid = 1'b1;
        for (int k = 0; k < 60 && !acc; k++) begin
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
        end
        total++;
        if (!acc) begin bad++; $display("FAIL lookup_accept char=%0d got in_ready=0 want 1", c); end
        else exp_q.push_back(ref_map(m, c));
    endtask

    task automatic cfg_beat(input logic [W-1:0] a, input logic [W-1:0] b, input bit last);
        bit acc = 0;
        cfg_a = a; cfg_b = b; cfg_last = last; cfg_valid = 1'b1;
        for (int k = 0; k < 60 && !acc; k++) begin
            @(negedge clk); acc = cfg_ready;
            @(posedge clk); #1;
        end
        cfg_valid = 1'b0; cfg_last = 1'b0;
        total++;
        if (!acc) begin bad++; $display("FAIL cfg_accept got cfg_ready=0 want 1"); end
        else model_beat(a, b, last);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!cfg_ready && n < 200) begin @(posedge clk); #1; n++; end
    endtask

    task automatic settle();
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        mode = 2'd2;
        repeat (3) @(negedge clk);
        total++; if (table_ok !== 1'b0)  begin bad++; $display("FAIL reset_table_ok got=%0b want=0", table_ok); end
        total++; if (cfg_err !== 1'b0)   begin bad++; $display("FAIL reset_cfg_err got=%0b want=0", cfg_err); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++; if (char_out !== 5'd0)  begin bad++; $display("FAIL reset_char_out got=%0d want=0", char_out); end
        total++; if (out_err !== 1'b0)   begin bad++; $display("FAIL reset_out_err got=%0b want=0", out_err); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_cfg_ready got=%0b want=1", cfg_ready); end
        total++; if (state_o !== 2'd0)   begin bad++; $display("FAIL reset_state got=%0d want=0", state_o); end
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL reset_mode2_in_ready got=%0b want=0", in_ready); end
        mode = 2'd0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_mode0_in_ready got=%0b want=1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_fixed();
        logic [W:0] got, want;
        logic [1:0] m;
        exp_q.delete(); obs_q.delete();
        lookup(2'd0, 5'd0, 0);  lookup(2'd0, 5'd25, 0);
        lookup(2'd1, 5'd0, 0);  lookup(2'd1, 5'd16, 0);
        for (int k = 0; k < 30; k++) begin
            m = 2'($urandom_range(0, 3));
            if (m == 2'd2) m = 2'd3;
            lookup(m, W'($urandom_range(0, 31)), 1);
        end
        settle();
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL fixed_resp missing want=%h", want); end
            else begin
                got = obs_q.pop_front();
                if (got !== want) begin bad++; $display("FAIL fixed_resp got=%h want=%h", got, want); end
            end
        end
    endtask

    task automatic test_prog();
        logic [W:0] got, want;
        int n;
        for (int i = 0; i < 13; i++) cfg_beat(W'(i), W'(i + 13), i == 12);
        wait_ready(n);
        total++; if (n !== CHK_LAT)        begin bad++; $display("FAIL prog_latency got=%0d want=%0d", n, CHK_LAT); end
        total++; if (table_ok !== ref_ok)  begin bad++; $display("FAIL prog_table_ok got=%0b want=%0b", table_ok, ref_ok); end
        total++; if (cfg_err !== ref_err)  begin bad++; $display("FAIL prog_cfg_err got=%0b want=%0b", cfg_err, ref_err); end
        exp_q.delete(); obs_q.delete();
        lookup(2'd2, 5'd3, 0);
        for (int k = 0; k < 20; k++) lookup(2'd2, W'($urandom_range(0, 31)), 1);
        settle();
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL prog_resp missing want=%h", want); end
            else begin
                got = obs_q.pop_front();
                if (got !== want) begin bad++; $display("FAIL prog_resp got=%h want=%h", got, want); end
            end
        end
    endtask

    task automatic test_missing_pair();
        int n;
        for (int i = 0; i < 12; i++) cfg_beat(W'(i), W'(i + 13), i == 11);
        wait_ready(n);
        total++; if (n !== CHK_LAT)        begin bad++; $display("FAIL missing_latency got=%0d want=%0d", n, CHK_LAT); end
        total++; if (table_ok !== ref_ok)  begin bad++; $display("FAIL missing_table_ok got=%0b want=%0b", table_ok, ref_ok); end
        total++; if (cfg_err !== ref_err)  begin bad++; $display("FAIL missing_cfg_err got=%0b want=%0b", cfg_err, ref_err); end
        mode = 2'd2;
        @(negedge clk);
        total++; if (in_ready !== ref_ok)  begin bad++; $display("FAIL missing_mode2_in_ready got=%0b want=%0b", in_ready, ref_ok); end
        mode = 2'd1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1)    begin bad++; $display("FAIL missing_mode1_in_ready got=%0b want=1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_random_load();
        logic [W:0] got, want;
        logic [1:0] m;
        int p [N_SYM];
        int qa[$];
        int qb[$];
        int n, j, t;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N_SYM; i++) p[i] = i;
            for (int i = N_SYM - 1; i > 0; i--) begin
                j = int'($urandom_range(0, i)); t = p[i]; p[i] = p[j]; p[j] = t;
            end
            qa.delete(); qb.delete();
            for (int k = 0; k < N_SYM / 2; k++) begin qa.push_back(p[2*k]); qb.push_back(p[2*k+1]); end
            if (r == 1) begin
                qa.insert(qa.size() - 1, int'($urandom_range(0, N_SYM - 1)));
                qb.insert(qb.size() - 1, int'($urandom_range(0, N_SYM - 1)));
            end
            if (r == 2) begin
                qa.insert(6, int'($urandom_range(N_SYM, 31)));
                qb.insert(6, p[0]);
            end
            for (int k = 0; k < qa.size(); k++) cfg_beat(W'(qa[k]), W'(qb[k]), k == qa.size() - 1);
            wait_ready(n);
            total++; if (n !== CHK_LAT)       begin bad++; $display("FAIL rnd_latency r=%0d got=%0d want=%0d", r, n, CHK_LAT); end
            total++; if (table_ok !== ref_ok) begin bad++; $display("FAIL rnd_table_ok r=%0d got=%0b want=%0b", r, table_ok, ref_ok); end
            total++; if (cfg_err !== ref_err) begin bad++; $display("FAIL rnd_cfg_err r=%0d got=%0b want=%0b", r, cfg_err, ref_err); end
            exp_q.delete(); obs_q.delete();
            for (int k = 0; k < 12; k++) begin
                m = ref_ok ? 2'd2 : 2'($urandom_range(0, 1));
                lookup(m, W'($urandom_range(0, 31)), 1);
            end
            settle();
            while (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                total++;
                if (obs_q.size() == 0) begin bad++; $display("FAIL rnd_resp missing want=%h", want); end
                else begin
                    got = obs_q.pop_front();
                    if (got !== want) begin bad++; $display("FAIL rnd_resp r=%0d got=%h want=%h", r, got, want); end
                end
            end
            mode = 2'd2;
            @(negedge clk);
            total++; if (in_ready !== ref_ok) begin bad++; $display("FAIL rnd_mode2_in_ready got=%0b want=%0b", in_ready, ref_ok); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] got, want, first;
        exp_q.delete(); obs_q.delete(); cyc_q.delete();
        out_ready = 1'b0;
        lookup(2'd0, 5'd7, 0);
        first = ref_map(2'd0, 5'd7);
        char_in = 5'd8;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({out_valid, out_err, char_out} !== {1'b1, first}) begin
                bad++; $display("FAIL bp_hold got v=%0b e=%0b c=%0d want v=1 data=%h", out_valid, out_err, char_out, first);
            end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%0b want=0", in_ready); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        lookup(2'd0, 5'd8, 0); lookup(2'd0, 5'd9, 0); lookup(2'd0, 5'd10, 0);
        settle();
        total++;
        if (cyc_q.size() != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", cyc_q.size()); end
        else for (int k = 1; k < 4; k++) begin
            total++;
            if (cyc_q[k] != cyc_q[k-1] + 1) begin bad++; $display("FAIL b2b_gap k=%0d got=%0d want=1", k, cyc_q[k] - cyc_q[k-1]); end
        end
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL b2b_resp missing want=%h", want); end
            else begin
                got = obs_q.pop_front();
                if (got !== want) begin bad++; $display("FAIL b2b_resp got=%h want=%h", got, want); end
            end
        end
    endtask

    task automatic test_load_race();
        logic [W:0] got, want;
        bit acc_in, acc_cfg;
        int n;
        for (int i = 0; i < 13; i++) cfg_beat(W'(i), W'(i + 13), i == 12);
        wait_ready(n);
        exp_q.delete(); obs_q.delete();
        mode = 2'd2; char_in = 5'd3; in_valid = 1'b1;
        cfg_a = 5'd5; cfg_b = 5'd6; cfg_last = 1'b0; cfg_valid = 1'b1;
        @(negedge clk); acc_in = in_ready; acc_cfg = cfg_ready;
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_valid = 1'b0;
        total++;
        if (!(acc_in && acc_cfg)) begin bad++; $display("FAIL race_accept got in=%0b cfg=%0b want 1 1", acc_in, acc_cfg); end
        exp_q.push_back(ref_map(2'd2, 5'd3));
        model_beat(5'd5, 5'd6, 0);
        total++; if (table_ok !== ref_ok) begin bad++; $display("FAIL race_table_ok got=%0b want=%0b", table_ok, ref_ok); end
        for (int i = 0; i < 13; i++) cfg_beat(W'(i), W'(i + 13), i == 12);
        wait_ready(n);
        total++; if (table_ok !== ref_ok) begin bad++; $display("FAIL race_reload_ok got=%0b want=%0b", table_ok, ref_ok); end
        lookup(2'd2, 5'd5, 0); lookup(2'd2, 5'd6, 0); lookup(2'd2, 5'd19, 0);
        settle();
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL race_resp missing want=%h", want); end
            else begin
                got = obs_q.pop_front();
                if (got !== want) begin bad++; $display("FAIL race_resp got=%h want=%h", got, want); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W:0] got, want;
        int n;
        out_ready = 1'b0;
        lookup(2'd0, 5'd1, 0);
        in_valid = 1'b0;
        cfg_beat(5'd0, 5'd13, 0);
        cfg_beat(5'd1, 5'd14, CHK_LAT != 0);
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_pending got=%0b want=1", out_valid); end
        total++;
        if (state_o !== ((CHK_LAT != 0) ? 2'd2 : 2'd1)) begin bad++; $display("FAIL mid_state_before got=%0d", state_o); end
        rst_n = 1'b0;
        #1;
        total++; if (state_o !== 2'd0)   begin bad++; $display("FAIL mid_state got=%0d want=0", state_o); end
        total++; if (table_ok !== 1'b0)  begin bad++; $display("FAIL mid_table_ok got=%0b want=0", table_ok); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL mid_cfg_ready got=%0b want=1", cfg_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%0b want=0", out_valid); end
        total++; if (char_out !== 5'd0)  begin bad++; $display("FAIL mid_char_out got=%0d want=0", char_out); end
        model_reset();
        exp_q.delete(); obs_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1; mode = 2'd2;
        @(negedge clk);
        total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL mid_mode2_in_ready got=%0b want=0", in_ready); end
        @(posedge clk); #1;
        cfg_beat(5'd0, 5'd1, 1);
        wait_ready(n);
        total++; if (table_ok !== ref_ok) begin bad++; $display("FAIL mid_reload_ok got=%0b want=%0b", table_ok, ref_ok); end
        total++; if (cfg_err !== ref_err) begin bad++; $display("FAIL mid_reload_err got=%0b want=%0b", cfg_err, ref_err); end
        if (ref_ok) begin
            lookup(2'd2, 5'd0, 0); lookup(2'd2, 5'd5, 0); lookup(2'd2, 5'd13, 0);
        end
        settle();
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL mid_resp missing want=%h", want); end
            else begin
                got = obs_q.pop_front();
                if (got !== want) begin bad++; $display("FAIL mid_resp got=%h want=%h", got, want); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; mode = 2'd0;
        cfg_valid = 1'b0; cfg_a = '0; cfg_b = '0; cfg_last = 1'b0;
        in_valid = 1'b0; char_in = '0; out_ready = 1'b1;
        model_reset();
        test_reset();
        test_fixed();
        test_prog();
        test_missing_pair();
        test_random_load();
        test_back_to_back();
        test_load_race();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
